bsg_hammerblade_io_responder: RTL and testbench

Host-side endpoint for the single live manycore I/O link, the P port of the I/O router at global (x = `num_tiles_x_p`, y = 0). It receives forward request packets from tiles and BlackParrot, decodes a small register map (mailbox, finish, scratch, cycle counter), and returns one response packet per request on the reverse network. It sits outside the hammerblade top and connects to its `io_link_sif_o` / `io_link_sif_i` pair.

---
 rtl/bsg_hammerblade_io_responder.sv | 203 ++++++++++++++++++++
 tb/tb_bsg_hammerblade_io_responder.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bsg_hammerblade_io_responder.sv
// Host endpoint on the manycore I/O link P port: register map + one response per request.
// Define BSG_HAMMERBLADE_IO_RESPONDER_CYCLE_CTR_EN to build the 64-bit cycle counter.
module bsg_hammerblade_io_responder #(
    parameter int x_cord_width_p = 7,
    parameter int y_cord_width_p = 7,
    parameter int addr_width_p   = 28,
    parameter int data_width_p   = 32,
    parameter int mailbox_els_p  = 4,
    localparam int fwd_w_lp  = addr_width_p + 9 + data_width_p
                             + 2 * (x_cord_width_p + y_cord_width_p),
    localparam int rev_w_lp  = 7 + data_width_p + x_cord_width_p + y_cord_width_p,
    localparam int link_w_lp = fwd_w_lp + rev_w_lp + 4
) (
    input  logic                    clk_i,
    input  logic                    reset_i,
    input  logic [link_w_lp-1:0]    link_sif_i,
    output logic [link_w_lp-1:0]    link_sif_o,
    output logic                    mailbox_v_o,
    output logic [data_width_p-1:0] mailbox_data_o,
    input  logic                    mailbox_yumi_i,
    output logic                    finish_v_o,
    output logic [data_width_p-1:0] finish_code_o,
    output logic                    err_o
);
    localparam int ptr_w_lp  = $clog2(mailbox_els_p);
    localparam int cnt_w_lp  = ptr_w_lp + 1;
    localparam int mask_w_lp = data_width_p / 8;

    localparam logic [3:0] op_load_lp  = 4'd0;
    localparam logic [3:0] op_store_lp = 4'd1;
    localparam logic [3:0] op_sw_lp    = 4'd2;
    localparam logic [1:0] ret_credit_lp = 2'd0;
    localparam logic [1:0] ret_int_wb_lp = 2'd1;

    typedef struct packed {
        logic [addr_width_p-1:0]   addr;
        logic [3:0]                op;
        logic [4:0]                reg_id;
        logic [data_width_p-1:0]   payload;
        logic [y_cord_width_p-1:0] src_y;
        logic [x_cord_width_p-1:0] src_x;
        logic [y_cord_width_p-1:0] y_cord;
        logic [x_cord_width_p-1:0] x_cord;
    } fwd_pkt_s;

    typedef struct packed {
        logic [1:0]                pkt_type;
        logic [data_width_p-1:0]   data;
        logic [4:0]                reg_id;
        logic [y_cord_width_p-1:0] y_cord;
        logic [x_cord_width_p-1:0] x_cord;
    } rev_pkt_s;

    typedef enum logic {IDLE, RESP} state_e;

    state_e   state_q, state_d;
    rev_pkt_s rev_pkt_q, rev_pkt_d;
    logic [data_width_p-1:0] scratch_q, scratch_d;
    logic [data_width_p-1:0] finish_code_q, finish_code_d;
    logic finish_v_q, finish_v_d;
    logic err_q, err_d;
    logic [data_width_p-1:0] mem_q [mailbox_els_p];
    logic [data_width_p-1:0] mem_d [mailbox_els_p];
    logic [ptr_w_lp-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [cnt_w_lp-1:0] count_q, count_d;

    fwd_pkt_s fwd_pkt;
    logic fwd_v, rev_ready, fwd_ready, push, pop, full;
    logic hi_zero, addr_ok, is_load, is_store, req_ok, mbox_store;
    logic [3:0] idx;
    logic [data_width_p-1:0] rdata, ctr_rdata;
    logic unused_bits;

    assign fwd_v     = link_sif_i[link_w_lp-1];
    assign fwd_pkt   = fwd_pkt_s'(link_sif_i[link_w_lp-2 -: fwd_w_lp]);
    assign rev_ready = link_sif_i[0];
    assign unused_bits = ^{link_sif_i[rev_w_lp+2:1], fwd_pkt.y_cord, fwd_pkt.x_cord};

    assign idx        = fwd_pkt.addr[3:0];
    assign hi_zero    = fwd_pkt.addr[addr_width_p-1:4] == '0;
    assign addr_ok    = hi_zero & (idx < 4'd4);
    assign is_load    = fwd_pkt.op == op_load_lp;
    assign is_store   = (fwd_pkt.op == op_store_lp) | (fwd_pkt.op == op_sw_lp);
    assign req_ok     = addr_ok & (is_load | is_store);
    assign mbox_store = req_ok & is_store & (idx == 4'd0);
    assign full       = count_q == cnt_w_lp'(mailbox_els_p);

`ifdef BSG_HAMMERBLADE_IO_RESPONDER_CYCLE_CTR_EN
    logic [63:0] ctr_q, ctr_d;
    assign ctr_d     = ctr_q + 64'd1;
    assign ctr_rdata = ctr_q[data_width_p-1:0];
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) ctr_q <= '0;
        else         ctr_q <= ctr_d;
    end
`else
    assign ctr_rdata = '0;
`endif

    always_comb begin
        state_d       = state_q;
        rev_pkt_d     = rev_pkt_q;
        scratch_d     = scratch_q;
        finish_v_d    = finish_v_q;
        finish_code_d = finish_code_q;
        err_d         = err_q;
        fwd_ready     = 1'b0;
        push          = 1'b0;
        case (idx)
            4'd0:    rdata = data_width_p'(count_q);
            4'd1:    rdata = data_width_p'(finish_v_q);
            4'd2:    rdata = ctr_rdata;
            4'd3:    rdata = scratch_q;
            default: rdata = '0;
        endcase
        unique case (state_q)
            IDLE: begin
                // a full mailbox back-pressures only mailbox stores
                fwd_ready = ~reset_i & ~(mbox_store & full);
                if (fwd_v & fwd_ready) begin
                    state_d            = RESP;
                    rev_pkt_d.x_cord   = fwd_pkt.src_x;
                    rev_pkt_d.y_cord   = fwd_pkt.src_y;
                    rev_pkt_d.reg_id   = fwd_pkt.reg_id;
                    rev_pkt_d.pkt_type = ret_int_wb_lp;
                    rev_pkt_d.data     = '0;
                    if (!req_ok) begin
                        err_d = 1'b1;
                    end else if (is_store) begin
                        rev_pkt_d.pkt_type = ret_credit_lp;
                        push = idx == 4'd0;
                        if (idx == 4'd1 && !finish_v_q) begin
                            finish_v_d    = 1'b1;
                            finish_code_d = fwd_pkt.payload;
                        end
                        if (idx == 4'd3) begin
                            for (int i = 0; i < mask_w_lp; i++) begin
                                if (fwd_pkt.op == op_sw_lp || fwd_pkt.reg_id[i])
                                    scratch_d[8*i +: 8] = fwd_pkt.payload[8*i +: 8];
                            end
                        end
                    end else begin
                        rev_pkt_d.data = rdata;
                    end
                end
            end
            RESP: if (rev_ready) state_d = IDLE;
        endcase
    end

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        pop      = mailbox_yumi_i & mailbox_v_o;
        if (push) begin
            mem_d[wr_ptr_q] = fwd_pkt.payload;
            wr_ptr_d        = wr_ptr_q + ptr_w_lp'(1);
        end
        if (pop) rd_ptr_d = rd_ptr_q + ptr_w_lp'(1);
        case ({push, pop})
            2'b10:   count_d = count_q + cnt_w_lp'(1);
            2'b01:   count_d = count_q - cnt_w_lp'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q       <= IDLE;
            rev_pkt_q     <= '0;
            scratch_q     <= '0;
            finish_v_q    <= 1'b0;
            finish_code_q <= '0;
            err_q         <= 1'b0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            for (int i = 0; i < mailbox_els_p; i++) mem_q[i] <= '0;
        end else begin
            state_q       <= state_d;
            rev_pkt_q     <= rev_pkt_d;
            scratch_q     <= scratch_d;
            finish_v_q    <= finish_v_d;
            finish_code_q <= finish_code_d;
            err_q         <= err_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            mem_q         <= mem_d;
        end
    end

    assign link_sif_o = {1'b0, {fwd_w_lp{1'b0}}, fwd_ready,
                         state_q == RESP, rev_pkt_q, 1'b1};

    assign mailbox_v_o    = count_q != '0;
    assign mailbox_data_o = mem_q[rd_ptr_q];
    assign finish_v_o     = finish_v_q;
    assign finish_code_o  = finish_code_q;
    assign err_o          = err_q;
endmodule

// File: tb/tb_bsg_hammerblade_io_responder.sv
// Bench for bsg_hammerblade_io_responder: queue/array model of the register map,
// per-cycle output compare, plus hand-computed literal expectations.
module tb_bsg_hammerblade_io_responder;
    localparam int X = 4, Y = 4, A = 12, D = 32, ELS = 4;
    localparam int FW = A + 9 + D + 2 * (X + Y);
    localparam int RW = 7 + D + X + Y;
    localparam int W  = FW + RW + 4;

    typedef struct packed {
        logic [A-1:0] addr;
        logic [3:0]   op;
        logic [4:0]   reg_id;
        logic [D-1:0] payload;
        logic [Y-1:0] src_y;
        logic [X-1:0] src_x;
        logic [Y-1:0] y_cord;
        logic [X-1:0] x_cord;
    } fwd_pkt_s;

    typedef struct packed {
        logic [1:0]   pkt_type;
        logic [D-1:0] data;
        logic [4:0]   reg_id;
        logic [Y-1:0] y_cord;
        logic [X-1:0] x_cord;
    } rev_pkt_s;

    typedef struct {
        logic [1:0]   t;
        logic [D-1:0] lo;
        logic [D-1:0] hi;
        logic [4:0]   rid;
        logic [X-1:0] x;
        logic [Y-1:0] y;
    } exp_s;

    logic clk = 1'b0, rst = 1'b1;
    logic fwd_v_i = 1'b0, rev_rdy_i = 1'b1, yumi = 1'b0;
    fwd_pkt_s fwd_pkt_i = '0;
    logic [W-1:0] sif_i, sif_o;
    logic mbv, finv, err;
    logic [D-1:0] mbd, fcode;

    logic o_fwd_v, o_rdy, o_rev_v, o_rev_rdy;
    rev_pkt_s o_rev;

    assign sif_i     = {fwd_v_i, fwd_pkt_i, 1'b0, 1'b0, {RW{1'b0}}, rev_rdy_i};
    assign o_fwd_v   = sif_o[W-1];
    assign o_rdy     = sif_o[RW+2];
    assign o_rev_v   = sif_o[RW+1];
    assign o_rev     = rev_pkt_s'(sif_o[RW:1]);
    assign o_rev_rdy = sif_o[0];

    bsg_hammerblade_io_responder #(
        .x_cord_width_p(X), .y_cord_width_p(Y), .addr_width_p(A),
        .data_width_p(D), .mailbox_els_p(ELS)
    ) dut (
        .clk_i(clk), .reset_i(rst), .link_sif_i(sif_i), .link_sif_o(sif_o),
        .mailbox_v_o(mbv), .mailbox_data_o(mbd), .mailbox_yumi_i(yumi),
        .finish_v_o(finv), .finish_code_o(fcode), .err_o(err)
    );

    always #5 clk = ~clk;

    int cyc;
    always @(posedge clk or posedge rst) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    logic [D-1:0] mq [$];
    exp_s eq [$];
    logic [D-1:0] m_scr, m_code;
    bit m_fin, m_err, chk_en;
    rev_pkt_s last_rsp;
    int tests = 0, fails = 0, last_acc = 0;

    task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
        tests++;
        if (a !== e) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", n, a, e);
        end
    endtask

    task automatic chk_range(input string n, input logic [63:0] a,
                             input logic [63:0] lo, input logic [63:0] hi);
        tests++;
        if (a < lo || a > hi) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h..0x%0h", n, a, lo, hi);
        end
    endtask

    function automatic bit is_mbox_store(input fwd_pkt_s p);
        return (p.op == 4'd1 || p.op == 4'd2) && p.addr == '0;
    endfunction

    always @(negedge clk) begin
        if (chk_en) begin
            chk("fwd_ready", o_rdy, eq.size() == 0 &&
                !(fwd_v_i && is_mbox_store(fwd_pkt_i) && mq.size() == ELS));
            chk("fwd_v_out", o_fwd_v, 0);
            chk("rev_ready_out", o_rev_rdy, 1);
            chk("mailbox_v", mbv, mq.size() != 0);
            if (mq.size() != 0) chk("mailbox_data", mbd, mq[0]);
            chk("finish_v", finv, m_fin);
            chk("finish_code", fcode, m_code);
            chk("err", err, m_err);
            if (eq.size() != 0) chk("rev_v", o_rev_v, 1);
            if (o_rev_v) begin
                if (eq.size() == 0) begin
                    chk("rev_unexpected", o_rev_v, 0);
                end else begin
                    chk("rev_type", o_rev.pkt_type, eq[0].t);
                    chk_range("rev_data", o_rev.data, eq[0].lo, eq[0].hi);
                    chk("rev_reg_id", o_rev.reg_id, eq[0].rid);
                    chk("rev_x", o_rev.x_cord, eq[0].x);
                    chk("rev_y", o_rev.y_cord, eq[0].y);
                    last_rsp = o_rev;
                    if (rev_rdy_i) void'(eq.pop_front());
                end
            end
        end
    end

    task automatic model_apply(input fwd_pkt_s p);
        exp_s e;
        bit ok, ld, st;
        ok = p.addr[A-1:4] == '0 && p.addr[3:0] < 4'd4;
        ld = p.op == 4'd0;
        st = p.op == 4'd1 || p.op == 4'd2;
        e.rid = p.reg_id;
        e.x = p.src_x;
        e.y = p.src_y;
        e.t = 2'd1;
        e.lo = '0;
        e.hi = '0;
        if (!ok || !(ld || st)) begin
            m_err = 1;
        end else if (st) begin
            e.t = 2'd0;
            case (p.addr[1:0])
                2'd0: mq.push_back(p.payload);
                2'd1: if (!m_fin) begin m_fin = 1; m_code = p.payload; end
                2'd3: for (int b = 0; b < 4; b++)
                          if (p.op == 4'd2 || p.reg_id[b]) m_scr[8*b +: 8] = p.payload[8*b +: 8];
                default: ;
            endcase
        end else begin
            case (p.addr[1:0])
                2'd0: begin e.lo = D'(mq.size()); e.hi = e.lo; end
                2'd1: begin e.lo = D'(m_fin); e.hi = e.lo; end
`ifdef BSG_HAMMERBLADE_IO_RESPONDER_CYCLE_CTR_EN
                2'd2: begin e.lo = D'(cyc - 4); e.hi = D'(cyc + 2); end
`endif
                2'd3: begin e.lo = m_scr; e.hi = m_scr; end
                default: ;
            endcase
        end
        eq.push_back(e);
    endtask

    task automatic req(input logic [3:0] op, input logic [A-1:0] addr,
                       input logic [4:0] rid, input logic [D-1:0] pl,
                       input logic [X-1:0] sx, input logic [Y-1:0] sy,
                       input bit wait_rsp, output int stalls);
        fwd_pkt_s p;
        p = '{addr: addr, op: op, reg_id: rid, payload: pl,
              src_y: sy, src_x: sx, y_cord: '0, x_cord: 4'd4};
        fwd_pkt_i = p;
        fwd_v_i = 1;
        stalls = 0;
        forever begin
            @(negedge clk);
            if (o_rdy) break;
            stalls++;
            if (stalls > 50) begin
                chk("accept_timeout", stalls, 0);
                fwd_v_i = 0;
                return;
            end
        end
        @(posedge clk);
        #1;
        fwd_v_i = 0;
        last_acc = cyc;
        model_apply(p);
        chk("rev_v_latency", o_rev_v, 1);
        if (wait_rsp) begin
            for (int i = 0; i <= 20; i++) begin
                @(posedge clk);
                #1;
                if (eq.size() == 0) break;
                if (i == 20) chk("rsp_timeout", eq.size(), 0);
            end
        end
    endtask

    task automatic pop();
        yumi = 1;
        @(posedge clk);
        #1;
        yumi = 0;
        void'(mq.pop_front());
    endtask

    task automatic chk_quiet(input string pfx, input bit rdy);
        chk({pfx, "_fwd_v"}, o_fwd_v, 0);
        chk({pfx, "_fwd_pkt_zero"}, sif_o[W-2 -: FW] == '0, 1);
        chk({pfx, "_fwd_rdy"}, o_rdy, rdy);
        chk({pfx, "_rev_v"}, o_rev_v, 0);
        chk({pfx, "_rev_pkt"}, 64'(sif_o[RW:1]), 0);
        chk({pfx, "_mbox_v"}, mbv, 0);
        chk({pfx, "_mbox_data"}, mbd, 0);
        chk({pfx, "_finish_v"}, finv, 0);
        chk({pfx, "_finish_code"}, fcode, 0);
        chk({pfx, "_err"}, err, 0);
    endtask

    task automatic do_reset();
        chk_en = 0;
        rst = 1;
        fwd_v_i = 0;
        yumi = 0;
        mq.delete();
        eq.delete();
        m_scr = '0;
        m_code = '0;
        m_fin = 0;
        m_err = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 0;
        @(posedge clk);
        #1;
        chk_en = 1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int st, a0;
        do_reset();
        chk_quiet("reset", 1);

        req(4'd1, 12'h0, 5'd5, 32'hDEADBEEF, 4'd2, 4'd3, 1, st);
        chk("t1_type", last_rsp.pkt_type, 2'd0);
        chk("t1_x", last_rsp.x_cord, 2);
        chk("t1_y", last_rsp.y_cord, 3);
        chk("t1_rid", last_rsp.reg_id, 5);
        chk("t1_data", last_rsp.data, 0);
        chk("t1_mbox_v", mbv, 1);
        chk("t1_mbox_data", mbd, 32'hDEADBEEF);
        pop();

        for (int i = 1; i <= 4; i++) req(4'd1, 12'h0, 5'd0, D'(i), 4'd1, 4'd1, 1, st);
        chk("full_head", mbd, 1);
        fork
            req(4'd1, 12'h0, 5'd0, 32'd5, 4'd1, 4'd1, 1, st);
            begin
                repeat (3) @(posedge clk);
                #1;
                pop();
            end
        join
        chk("full_stall_cycles", st, 4);
        req(4'd0, 12'h0, 5'd1, 32'd0, 4'd1, 4'd1, 1, st);
        chk("full_count", last_rsp.data, 4);
        repeat (4) pop();
        chk("drained", mbv, 0);

        req(4'd1, 12'h1, 5'd0, 32'd7, 4'd0, 4'd0, 1, st);
        req(4'd1, 12'h1, 5'd0, 32'd9, 4'd0, 4'd0, 1, st);
        chk("fin_code", fcode, 7);
        chk("fin_v", finv, 1);
        req(4'd0, 12'h1, 5'd2, 32'd0, 4'd0, 4'd0, 1, st);
        chk("fin_load", last_rsp.data, 1);
        chk("fin_load_type", last_rsp.pkt_type, 2'd1);

        req(4'd2, 12'h3, 5'd0, 32'h12345678, 4'd3, 4'd1, 1, st);
        req(4'd1, 12'h3, 5'b00010, 32'h0000AA00, 4'd3, 4'd1, 1, st);
        req(4'd0, 12'h3, 5'd9, 32'd0, 4'd3, 4'd1, 1, st);
        chk("scratch_mask", last_rsp.data, 32'h1234AA78);
        chk("no_err_yet", err, 0);

        req(4'd0, 12'h7, 5'd3, 32'd0, 4'd2, 4'd2, 1, st);
        chk("bad_addr_data", last_rsp.data, 0);
        chk("bad_addr_type", last_rsp.pkt_type, 2'd1);
        chk("bad_addr_err", err, 1);
        req(4'd4, 12'h3, 5'd3, 32'hFFFFFFFF, 4'd2, 4'd2, 1, st);
        req(4'd0, 12'h13, 5'd3, 32'd0, 4'd2, 4'd2, 1, st);
        chk("hi_addr_data", last_rsp.data, 0);
        req(4'd0, 12'h3, 5'd3, 32'd0, 4'd2, 4'd2, 1, st);
        chk("amo_no_write", last_rsp.data, 32'h1234AA78);
        chk("err_sticky", err, 1);

        req(4'd0, 12'h3, 5'd0, 32'd0, 4'd1, 4'd0, 1, st);
        a0 = last_acc;
        req(4'd0, 12'h3, 5'd0, 32'd0, 4'd1, 4'd0, 1, st);
        chk("throughput", last_acc - a0, 2);

        rev_rdy_i = 0;
        req(4'd0, 12'h3, 5'd6, 32'd0, 4'd5, 4'd6, 0, st);
        repeat (10) @(negedge clk);
        chk("hold_rev_v", o_rev_v, 1);
        chk("hold_rev_data", o_rev.data, 32'h1234AA78);
        chk("hold_fwd_rdy", o_rdy, 0);
        #2;
        chk_en = 0;
        rst = 1;
        #1;
        chk_quiet("midrst", 0);
        rev_rdy_i = 1;
        do_reset();

        repeat (99) @(posedge clk);
        #1;
        req(4'd0, 12'h2, 5'd0, 32'd0, 4'd1, 4'd1, 1, st);
`ifdef BSG_HAMMERBLADE_IO_RESPONDER_CYCLE_CTR_EN
        chk_range("ctr_100", last_rsp.data, 98, 102);
`else
        chk("ctr_off", last_rsp.data, 0);
`endif
        chk("ctr_no_err", err, 0);

        repeat (3) @(posedge clk);
        chk("no_pending", eq.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
